// File: rtl/i2c_master_reader.sv
// i2c_master_reader: I2C bus initiator that polls a read-only sensor with
// START, address+R, three data bytes (x_pos, y_pos, status) and STOP.
// SCL/SDA are open-drain: *_oe=1 pulls the line low, *_oe=0 releases it.
// Optional feature macro: I2C_CLK_STRETCH_EN (honour responder clock stretching).
// Handshake: start is sampled only while busy=0 (IDLE); done is a one-clk
// strobe marking the cycle in which x_pos/y_pos/status were refreshed together.
module i2c_master_reader #(
    parameter logic [6:0]  I2C_ADDR = 7'b1100100,
    parameter int unsigned QTR_DIV  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] x_pos,
    output logic [7:0] y_pos,
    output logic [7:0] status,
    output logic       done,
    output logic       busy,
    output logic       nack_err,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_READ, S_MACK, S_STOP, S_DONE
    } state_t;

    localparam int          QW        = $clog2(QTR_DIV);
    localparam logic [QW-1:0] QMAX    = QW'(QTR_DIV - 1);
    localparam logic [7:0]  ADDR_BYTE = {I2C_ADDR, 1'b1};

    state_t        state, state_nx;
    logic [QW-1:0] qcnt;
    logic [1:0]    q;
    logic [3:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [7:0]    shreg, byte0, byte1;
    logic          sda_m, sda_s;
    logic          timer_hold, qtick, cell_end, sample_now;

    // SDA pin synchroniser; idle bus level is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {sda_s, sda_m} <= 2'b11;
        else     {sda_s, sda_m} <= {sda_m, sda_in};
    end

`ifdef I2C_CLK_STRETCH_EN
    logic scl_m, scl_s;
    // SCL pin synchroniser, used to detect a responder holding SCL low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {scl_s, scl_m} <= 2'b11;
        else     {scl_s, scl_m} <= {scl_m, scl_in};
    end
    // Q2 waits until the released SCL is actually seen high
    assign timer_hold = (q == 2'd2) && !scl_s;
`else
    logic unused_scl;
    assign unused_scl = scl_in;
    assign timer_hold = 1'b0;
`endif

    assign qtick      = (qcnt == QMAX) && !timer_hold;
    assign cell_end   = qtick && (q == 2'd3);
    assign sample_now = qtick && (q == 2'd2) &&
                        ((state == S_ADDR_ACK) || (state == S_READ));
    assign dbg_state  = state;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next state and open-drain/status outputs
    always_comb begin
        state_nx = state;
        scl_oe   = 1'b0;
        sda_oe   = 1'b0;
        done     = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_START;
            end
            S_START: begin
                sda_oe = 1'b1;
                if (qtick && (q == 2'd1)) state_nx = S_ADDR;
            end
            S_ADDR: begin
                scl_oe = ~q[1];
                sda_oe = ~ADDR_BYTE[3'd7 - bit_cnt[2:0]];
                if (cell_end && (bit_cnt == 4'd7)) state_nx = S_ADDR_ACK;
            end
            S_ADDR_ACK: begin
                scl_oe = ~q[1];
                if (cell_end) state_nx = shreg[0] ? S_STOP : S_READ;
            end
            S_READ: begin
                scl_oe = ~q[1];
                if (cell_end && (bit_cnt == 4'd7)) state_nx = S_MACK;
            end
            S_MACK: begin
                scl_oe = ~q[1];
                sda_oe = (byte_cnt != 2'd2);
                if (cell_end) state_nx = (byte_cnt == 2'd2) ? S_STOP : S_READ;
            end
            S_STOP: begin
                scl_oe = ~q[1];
                sda_oe = (q != 2'd3);
                if (cell_end) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = !nack_err;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Quarter timer: restarts on every state change so each state begins at Q0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qcnt <= '0;
            q    <= 2'd0;
        end else if ((state == S_IDLE) || (state_nx != state)) begin
            qcnt <= '0;
            q    <= 2'd0;
        end else if (!timer_hold) begin
            if (qcnt == QMAX) begin
                qcnt <= '0;
                q    <= q + 2'd1;
            end else begin
                qcnt <= qcnt + QW'(1);
            end
        end
    end

    // Bit/byte counters, receive shifter and output byte registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= 4'd0;
            byte_cnt <= 2'd0;
            shreg    <= 8'd0;
            byte0    <= 8'd0;
            byte1    <= 8'd0;
            nack_err <= 1'b0;
            x_pos    <= 8'd0;
            y_pos    <= 8'd0;
            status   <= 8'd0;
        end else begin
            if ((state == S_IDLE) && start) begin
                bit_cnt  <= 4'd0;
                byte_cnt <= 2'd0;
                nack_err <= 1'b0;
            end
            if (sample_now) shreg <= {shreg[6:0], sda_s};
            if (cell_end && ((state == S_ADDR) || (state == S_READ)))
                bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
            if (cell_end && (state == S_READ) && (bit_cnt == 4'd7)) begin
                if (byte_cnt == 2'd0) byte0 <= shreg;
                if (byte_cnt == 2'd1) byte1 <= shreg;
            end
            if (cell_end && (state == S_MACK) && (byte_cnt != 2'd2))
                byte_cnt <= byte_cnt + 2'd1;
            if (cell_end && (state == S_ADDR_ACK) && shreg[0])
                nack_err <= 1'b1;
            // byte 2 is still in the shifter; all three land together as DONE begins
            if (cell_end && (state == S_STOP) && !nack_err) begin
                x_pos  <= byte0;
                y_pos  <= byte1;
                status <= shreg;
            end
        end
    end

endmodule
